// File: rtl/bus_resp_sram_if.sv
`default_nettype none
// ============================================================================
// bus_resp_sram_if : ibus (m0) / dbus (m1) signal bundle for bus_resp_sram
// Revision: 1.0
// ============================================================================
interface bus_resp_sram_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_as;
  logic              m0_rw;
  logic [DATA_W-1:0] m0_wr_data;
  logic              m0_get;
  logic              m0_ready;
  logic [DATA_W-1:0] m0_rd_data;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_as;
  logic              m1_rw;
  logic [DATA_W-1:0] m1_wr_data;
  logic              m1_get;
  logic              m1_ready;
  logic [DATA_W-1:0] m1_rd_data;

  modport master (
    output m0_req, m0_addr, m0_as, m0_rw, m0_wr_data,
    output m1_req, m1_addr, m1_as, m1_rw, m1_wr_data,
    input  m0_get, m0_ready, m0_rd_data,
    input  m1_get, m1_ready, m1_rd_data
  );

  modport slave (
    input  m0_req, m0_addr, m0_as, m0_rw, m0_wr_data,
    input  m1_req, m1_addr, m1_as, m1_rw, m1_wr_data,
    output m0_get, m0_ready, m0_rd_data,
    output m1_get, m1_ready, m1_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/bus_resp_sram.sv
`default_nettype none
// ============================================================================
// bus_resp_sram : round-robin two-master bus responder backed by a word SRAM
// Optional grant watchdog compiled in with `define BUS_RESP_TIMEOUT_EN
// Revision: 1.0
// ============================================================================
module bus_resp_sram #(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int MEM_AW         = 10,
  parameter int WAIT_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire            clk,
  input  wire            rst,
  bus_resp_sram_if.slave bus,
  output logic           timeout_o
);

  localparam int         c_depth     = 1 << MEM_AW;
  localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2,
    S_READY = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_owner;
  logic                r_last;
  logic [3:0]          r_wait_cnt;
  logic [MEM_AW-1:0]   r_idx;
  logic                r_rw;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_get;
  logic [1:0]          r_ready_n;
  logic [DATA_W-1:0]   r_rd_data0;
  logic [DATA_W-1:0]   r_rd_data1;
  logic [DATA_W-1:0]   r_mem [c_depth];

  logic                w_own_req;
  logic                w_own_as_n;
  logic                w_own_rw;
  logic [ADDR_W-1:0]   w_own_addr;
  logic [DATA_W-1:0]   w_own_wdata;
  logic                w_pick;
  logic [MEM_AW-1:0]   w_acc_idx;
  logic                w_acc_rw;
  logic [DATA_W-1:0]   w_rd_word;
  logic                w_unused_addr_hi;

`ifdef BUS_RESP_TIMEOUT_EN
  localparam int              c_wd_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT_CYCLES - 1);
  logic [c_wd_w-1:0]          r_wd_cnt;
  logic                       r_timeout;
  assign timeout_o = r_timeout;
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
  assign timeout_o = 1'b0;
`endif

  // Only the current owner's strobes are ever looked at.
  always_comb begin
    if (r_owner) begin
      w_own_req   = bus.m1_req;
      w_own_as_n  = bus.m1_as;
      w_own_rw    = bus.m1_rw;
      w_own_addr  = bus.m1_addr;
      w_own_wdata = bus.m1_wr_data;
    end else begin
      w_own_req   = bus.m0_req;
      w_own_as_n  = bus.m0_as;
      w_own_rw    = bus.m0_rw;
      w_own_addr  = bus.m0_addr;
      w_own_wdata = bus.m0_wr_data;
    end
  end

  assign w_pick           = (bus.m0_req && bus.m1_req) ? ~r_last : bus.m1_req;
  assign w_unused_addr_hi = ^w_own_addr[ADDR_W-1:MEM_AW];

  // With zero wait states READY is entered straight from GRANT, before the
  // access has been latched, so the read path takes the live bus fields then.
  assign w_acc_idx = (r_state == S_GRANT) ? w_own_addr[MEM_AW-1:0] : r_idx;
  assign w_acc_rw  = (r_state == S_GRANT) ? w_own_rw : r_rw;
  assign w_rd_word = w_acc_rw ? r_mem[w_acc_idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_wait_cnt <= 4'd0;
      r_idx      <= '0;
      r_rw       <= 1'b1;
      r_wdata    <= '0;
      r_get      <= 2'b00;
      r_ready_n  <= 2'b11;
      r_rd_data0 <= '0;
      r_rd_data1 <= '0;
`ifdef BUS_RESP_TIMEOUT_EN
      r_wd_cnt   <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_ready_n  <= 2'b11;
      r_rd_data0 <= '0;
      r_rd_data1 <= '0;
`ifdef BUS_RESP_TIMEOUT_EN
      r_timeout  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            r_owner <= w_pick;
            r_last  <= w_pick;
            r_get   <= w_pick ? 2'b10 : 2'b01;
            r_state <= S_GRANT;
          end
        end

        S_GRANT: begin
          if (!w_own_req) begin
            r_get   <= 2'b00;
            r_state <= S_IDLE;
`ifdef BUS_RESP_TIMEOUT_EN
            r_wd_cnt <= '0;
`endif
          end else if (!w_own_as_n) begin
            r_idx   <= w_own_addr[MEM_AW-1:0];
            r_rw    <= w_own_rw;
            r_wdata <= w_own_wdata;
`ifdef BUS_RESP_TIMEOUT_EN
            r_wd_cnt <= '0;
`endif
            if (c_wait_load == 4'd0) begin
              r_state            <= S_READY;
              r_ready_n[r_owner] <= 1'b0;
              if (r_owner) r_rd_data1 <= w_rd_word;
              else         r_rd_data0 <= w_rd_word;
            end else begin
              r_wait_cnt <= c_wait_load;
              r_state    <= S_WAIT;
            end
          end
`ifdef BUS_RESP_TIMEOUT_EN
          else if (r_wd_cnt == c_wd_last) begin
            r_get     <= 2'b00;
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
            r_last    <= r_owner;
            r_wd_cnt  <= '0;
          end else begin
            r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
          end
`endif
        end

        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
          if (r_wait_cnt == 4'd1) begin
            r_state            <= S_READY;
            r_ready_n[r_owner] <= 1'b0;
            if (r_owner) r_rd_data1 <= w_rd_word;
            else         r_rd_data0 <= w_rd_word;
          end
        end

        S_READY: begin
          if (w_own_req) begin
            r_state <= S_GRANT;
          end else begin
            r_get   <= 2'b00;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write commits on the edge that ends READY; a reset on that edge cancels it.
  always_ff @(posedge clk) begin
    if (rst && (r_state == S_READY) && !r_rw) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign bus.m0_get     = r_get[0];
  assign bus.m1_get     = r_get[1];
  assign bus.m0_ready   = r_ready_n[0];
  assign bus.m1_ready   = r_ready_n[1];
  assign bus.m0_rd_data = r_rd_data0;
  assign bus.m1_rd_data = r_rd_data1;

endmodule
`default_nettype wire

// File: tb/tb_bus_resp_sram.sv
`default_nettype none
// ============================================================================
// tb_bus_resp_sram : vector table, directed corner sequences and random traffic
// Revision: 1.0
// ============================================================================
module tb_bus_resp_sram;

  localparam int W = 1;

  logic clk;
  logic rst;
  logic timeout1;
  logic timeout0;

  bus_resp_sram_if #(.ADDR_W(30), .DATA_W(32)) bus ();
  bus_resp_sram_if #(.ADDR_W(30), .DATA_W(32)) bz ();

  bus_resp_sram #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .timeout_o(timeout1)
  );

  bus_resp_sram #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .bus(bz), .timeout_o(timeout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_d, as_d, rw_d;
  logic [29:0] addr_d [2];
  logic [31:0] wd_d [2];
  logic [1:0]  get_s, ready_s;
  logic [31:0] rd_s [2];

  assign bus.m0_req     = req_d[0];
  assign bus.m1_req     = req_d[1];
  assign bus.m0_as      = as_d[0];
  assign bus.m1_as      = as_d[1];
  assign bus.m0_rw      = rw_d[0];
  assign bus.m1_rw      = rw_d[1];
  assign bus.m0_addr    = addr_d[0];
  assign bus.m1_addr    = addr_d[1];
  assign bus.m0_wr_data = wd_d[0];
  assign bus.m1_wr_data = wd_d[1];
  assign get_s          = {bus.m1_get, bus.m0_get};
  assign ready_s        = {bus.m1_ready, bus.m0_ready};
  assign rd_s[0]        = bus.m0_rd_data;
  assign rd_s[1]        = bus.m1_rd_data;

  int checks   = 0;
  int failures = 0;

  // Reference memory: what each index should hold after completed writes.
  logic [31:0] ref_mem [1024];
  bit          ref_valid [1024];
  int          wq [$];

  typedef struct {
    int          m;
    bit          rw;
    logic [29:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          noise;
  } vec_t;

  vec_t vt [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_write(input logic [29:0] addr, input logic [31:0] wd);
    int idx;
    idx = int'(addr[9:0]);
    ref_mem[idx] = wd;
    if (!ref_valid[idx]) begin
      ref_valid[idx] = 1'b1;
      wq.push_back(idx);
    end
  endtask

  // One complete access by master m starting from an idle bus.
  task automatic xact(input int m, input bit rw, input logic [29:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input bit noise);
    int o;
    logic [1:0] own_get, own_rdy;
    o       = 1 - m;
    own_get = (m == 1) ? 2'b10 : 2'b01;
    own_rdy = (m == 1) ? 2'b01 : 2'b10;
    req_d[m] = 1'b1;
    tick();
    chk("grant_latency", get_s, own_get);
    if (get_s !== own_get) begin
      req_d = 2'b00;
      tick();
    end else begin
      as_d[m] = 1'b0; rw_d[m] = rw; addr_d[m] = addr; wd_d[m] = wd;
      if (noise) begin
        req_d[o] = 1'b1; as_d[o] = 1'b0; rw_d[o] = 1'b0; addr_d[o] = addr; wd_d[o] = ~wd;
      end
      tick();
      as_d[m] = 1'b1;
      for (int j = 0; j < W; j++) begin
        chk("wait_ready_high", ready_s, 2'b11);
        chk("wait_rd_zero", rd_s[m], 32'h0);
        tick();
      end
      chk("ready_pulse", ready_s, own_rdy);
      chk("rd_data", rd_s[m], exp_rd);
      chk("nonowner_rd_zero", rd_s[o], 32'h0);
      chk("grant_hold", get_s, own_get);
      req_d = 2'b00;
      as_d  = 2'b11;
      tick();
      chk("release", {get_s, ready_s}, 4'b0011);
      chk("rd_after_ready", rd_s[m], 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    req_d = 2'b00; as_d = 2'b11; rw_d = 2'b11;
    addr_d[0] = '0; addr_d[1] = '0; wd_d[0] = '0; wd_d[1] = '0;
    bz.m0_req = 1'b0; bz.m0_as = 1'b1; bz.m0_rw = 1'b1; bz.m0_addr = '0; bz.m0_wr_data = '0;
    bz.m1_req = 1'b0; bz.m1_as = 1'b1; bz.m1_rw = 1'b1; bz.m1_addr = '0; bz.m1_wr_data = '0;
    for (int i = 0; i < 1024; i++) begin ref_valid[i] = 1'b0; ref_mem[i] = '0; end

    vt[0] = '{1, 1'b0, 30'h005,     32'hDEADBEEF, 32'h0,        1'b0};
    vt[1] = '{1, 1'b1, 30'h405,     32'h0,        32'hDEADBEEF, 1'b0};
    vt[2] = '{0, 1'b0, 30'h3FF,     32'h12345678, 32'h0,        1'b1};
    vt[3] = '{0, 1'b1, 30'h7FF,     32'h0,        32'h12345678, 1'b0};
    vt[4] = '{1, 1'b0, 30'h000,     32'hA5A5A5A5, 32'h0,        1'b0};
    vt[5] = '{0, 1'b1, 30'h2AB_C00, 32'h0,        32'hA5A5A5A5, 1'b1};
    vt[6] = '{0, 1'b0, 30'h005,     32'h00000001, 32'h0,        1'b0};
    vt[7] = '{1, 1'b1, 30'h3FF_C05, 32'h0,        32'h00000001, 1'b0};

    // Reset held while both masters request and strobe.
    rst = 1'b0;
    req_d = 2'b11; as_d = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outputs", {timeout1, get_s, ready_s}, 5'b00011);
      chk("rst_rd0", rd_s[0], 32'h0);
      chk("rst_rd1", rd_s[1], 32'h0);
      chk("rst_w0_outputs", {timeout0, bz.m0_get, bz.m0_ready, bz.m0_rd_data}, {3'b001, 32'h0});
    end
    as_d = 2'b11;
    rst  = 1'b1;
    tick();
    chk("first_grant_m0", get_s, 2'b01);
    req_d[0] = 1'b0;
    tick();
    chk("handover_idle", get_s, 2'b00);
    tick();
    chk("handover_m1", get_s, 2'b10);
    req_d = 2'b01;
    tick();
    chk("alt_release_m1", get_s, 2'b00);
    req_d = 2'b11;
    tick();
    chk("alt_grant_m0", get_s, 2'b01);
    req_d = 2'b10;
    tick();
    chk("alt_release_m0", get_s, 2'b00);
    req_d = 2'b11;
    tick();
    chk("alt_grant_m1", get_s, 2'b10);
    req_d = 2'b00;
    tick();
    chk("alt_idle", get_s, 2'b00);

    // Zero-wait instance: one write, then four back-to-back reads.
    bz.m0_req = 1'b1;
    tick();
    chk("w0_grant", bz.m0_get, 1'b1);
    bz.m0_as = 1'b0; bz.m0_rw = 1'b0; bz.m0_addr = 30'h009; bz.m0_wr_data = 32'hCAFEF00D;
    tick();
    chk("w0_write_ready", {bz.m0_ready, bz.m0_rd_data}, {1'b0, 32'h0});
    bz.m0_rw = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("w0_gap", {bz.m0_ready, bz.m0_rd_data}, {1'b1, 32'h0});
      tick();
      chk("w0_read_pulse", {bz.m0_ready, bz.m0_rd_data}, {1'b0, 32'hCAFEF00D});
    end
    bz.m0_as = 1'b1; bz.m0_req = 1'b0;
    tick();
    chk("w0_release", {bz.m0_get, bz.m0_ready}, 2'b01);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      xact(vt[i].m, vt[i].rw, vt[i].addr, vt[i].wd, vt[i].exp_rd, vt[i].noise);
      if (!vt[i].rw) model_write(vt[i].addr, vt[i].wd);
    end

    // Reset landing in READY of a write must cancel that write.
    xact(0, 1'b0, 30'h007, 32'h11111111, 32'h0, 1'b0);
    model_write(30'h007, 32'h11111111);
    req_d[0] = 1'b1;
    tick();
    chk("abort_grant", get_s, 2'b01);
    as_d[0] = 1'b0; rw_d[0] = 1'b0; addr_d[0] = 30'h007; wd_d[0] = 32'h22222222;
    tick();
    as_d[0] = 1'b1;
    tick();
    chk("abort_ready", ready_s, 2'b10);
    rst = 1'b0; req_d = 2'b00;
    tick();
    chk("abort_reset_outputs", {get_s, ready_s}, 4'b0011);
    rst = 1'b1;
    tick();
    xact(1, 1'b1, 30'h1407, 32'h0, ref_mem[7], 1'b0);

    // Random traffic against the reference memory.
    for (int n = 0; n < 40; n++) begin
      int          m, idx;
      bit          rw, noise;
      logic [29:0] a;
      logic [31:0] d;
      m     = int'($urandom_range(0, 1));
      noise = 1'($urandom_range(0, 1));
      a     = 30'($urandom);
      d     = $urandom;
      rw    = (wq.size() > 0) && ($urandom_range(0, 1) == 1);
      if (rw) begin
        idx     = wq[$urandom_range(0, wq.size() - 1)];
        a[9:0]  = 10'(idx);
        xact(m, 1'b1, a, 32'h0, ref_mem[idx], noise);
      end else begin
        xact(m, 1'b0, a, d, 32'h0, noise);
        model_write(a, d);
      end
    end

`ifdef BUS_RESP_TIMEOUT_EN
    req_d[0] = 1'b1;
    tick();
    chk("wd_grant", get_s, 2'b01);
    req_d[1] = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("wd_hold", {timeout1, get_s}, 3'b001);
    end
    tick();
    chk("wd_expire", {timeout1, get_s}, 3'b100);
    tick();
    chk("wd_handover", {timeout1, get_s}, 3'b010);
`else
    req_d[0] = 1'b1;
    tick();
    chk("hold_grant_start", get_s, 2'b01);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("hold_grant", {timeout1, get_s}, 3'b001);
    end
`endif
    req_d = 2'b00;
    tick();
    tick();
    chk("final_idle", {timeout1, get_s, ready_s}, 5'b00011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_resp_sram.md
# bus_resp_sram

Bus responder and two-master arbiter at the target end of the CPU's instruction and data bus interfaces. It accepts bus requests from the ibus initiator (master 0) and the dbus initiator (master 1) and grants the bus to one of them with round-robin arbitration. It services each granted access from an internal single-port word memory, inserting a programmable number of wait states before signalling ready. It sits at SoC level between the CPU core's ibus/dbus ports and on-chip RAM.

## Interface
- ADDR_W, 30, word-address width of the bus.
- DATA_W, 32, data word width.
- MEM_AW, 10, memory index width; the memory holds 2^MEM_AW words, indexed by `addr[MEM_AW-1:0]`.
- WAIT_CYCLES, 1, number of wait states between accepting an access and asserting ready. Legal range is 0..15.
- TIMEOUT_CYCLES, 16, grant watchdog limit. Used only when the feature under Configuration is compiled in.

Ports (name, direction, width, meaning):
- clk  in  1  Single clock; all logic is on the rising edge.
- rst  in  1  Synchronous reset, active-low.
- m0_req / m1_req  in  1  Bus request from master 0 / master 1, active-high.
- m0_addr / m1_addr  in  ADDR_W  Word address.
- m0_as / m1_as  in  1  Address strobe, active-low.
- m0_rw / m1_rw  in  1  Access direction: 1 = read, 0 = write.
- m0_wr_data / m1_wr_data  in  DATA_W  Write data.
- m0_get / m1_get  out  1  Bus grant, active-high, registered.
- m0_ready / m1_ready  out  1  Access complete, active-low, registered.
- m0_rd_data / m1_rd_data  out  DATA_W  Read data, registered.
- timeout_o  out  1  Grant-watchdog expiry, one-cycle pulse.

## Operation
- State machine states are IDLE, GRANT, WAIT and READY. The module also holds `owner` (0/1) and `last` (the most recent owner). On reset, `last` = 1, so master 0 wins the first tie.
- **IDLE:** if any request is high, grant it. If both are high, grant the master that is not `last`. The next state is GRANT, with `owner` and `last` updated and `mX_get` = 1 for the owner.
- **GRANT:**
  - Owner request low: drop get and return to IDLE.
  - Owner asserts as (low): latch addr, rw and wr_data and load the wait counter with WAIT_CYCLES. Go to WAIT, or go directly to READY if WAIT_CYCLES = 0.
- **WAIT:** decrement the counter each cycle. Enter READY when the counter reaches 0. Changes on the owner's req and as are ignored.
- **READY:** `mX_ready` = 0 for exactly one cycle.
  - Reads: `mX_rd_data` = mem[latched index] for that cycle.
  - Writes: the memory is updated at the edge that ends READY.
  - Next state is GRANT if the owner's req is still high, otherwise IDLE, with get dropping on that edge.
- Strobes from the non-owner are ignored entirely. A request from the non-owner waits until the owner releases the bus.
- Address bits at and above MEM_AW are ignored; addresses alias modulo 2^MEM_AW.
- `rd_data` is 0 in every cycle other than READY, and also during READY for writes. `rd_data` for the non-owner is always 0.
- **Reset:** takes priority over everything, including mid-access. After reset:
  - State is IDLE.
  - m0_get = m1_get = 0.
  - m0_ready = m1_ready = 1.
  - Both rd_data = 0.
  - timeout_o = 0.
  - The counters are 0.
  - Memory contents are not cleared.
  - A write in flight when reset is asserted does not complete.

## Timing
- req seen high at edge t gives get high from edge t+1.
- The access is accepted at the first edge where get = 1 and as = 0.
- ready falls WAIT_CYCLES+1 edges after acceptance and stays low for one cycle.
- A new access from the same owner can be accepted one cycle after READY, giving a throughput of WAIT_CYCLES+2 cycles per access.
- Releasing the bus takes one cycle: req low at edge t gives get low from edge t+1.
- A handover from one master to the other takes one idle cycle.
- Read-after-write to the same address returns the new data.

## Configuration
- `BUS_RESP_TIMEOUT_EN` defined:
  - In GRANT, a counter increments every cycle that the owner's req is high and as is high.
  - When the counter reaches TIMEOUT_CYCLES, drop get, go to IDLE, pulse timeout_o for one cycle and set `last` = owner.
  - The counter clears on acceptance, on release and on reset.
- Not defined: no watchdog counter exists, timeout_o is tied to 0, and the owner may hold the grant indefinitely.

## Test plan
- **Reset:** hold rst = 0 for 3 cycles while driving requests. Outputs must be get = 0, ready = 1, rd_data = 0 and timeout_o = 0, and no grant may issue until the cycle after rst = 1.
- **Write then read, WAIT_CYCLES = 1:**
  - m1 writes 0xDEADBEEF to addr 0x5. ready must fall 2 edges after acceptance.
  - m1 then reads addr 0x405, which aliases to 0x5 with MEM_AW = 10. rd_data must be 0xDEADBEEF in the ready cycle and 0 in all other cycles.
- **Simultaneous requests after reset:** m0 must be granted first. After m0 releases, m1 must be granted following one idle cycle. With both requests held continuously, grants must alternate.
- **Non-owner isolation:** m1 asserts as while m0 owns the bus and is in WAIT. m1_ready must stay 1 and memory must be unchanged by m1.
- **WAIT_CYCLES = 0:** a back-to-back sequence of 4 reads from m0 must produce ready pulses every 2 cycles.
- **Watchdog, with BUS_RESP_TIMEOUT_EN and TIMEOUT_CYCLES = 16:** m0 holds req high with as high. get must drop and timeout_o must pulse 16 cycles after the grant. If m1 is also requesting, it must be granted next.
